// File: rtl/apb_pkg.sv
// Shared state encodings and default parameters for the APB arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDR_WIDTH    = 32;
    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_TIMEOUT_CYCLE = 6;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin grant selection starting at ptr; also yields the pointer
// that follows the winner.
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] index,
    output logic [$clog2(NUM_REQ)-1:0] next_ptr
);

    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic               found;
    int                 sum;

    // Rotate so that bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        rot   = NUM_REQ'({req, req} >> ptr);
        found = 1'b0;
        sum   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
            end
        end
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        index    = IW'(sum);
        grant    = found ? (NUM_REQ'(1) << index) : '0;
        next_ptr = (index == IW'(NUM_REQ - 1)) ? '0 : index + 1'b1;
    end

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin APB master shared by NUM_REQ requesters, with access timeout.
// Define APB_SLVERR_EN to add apb_slverr_in and report slave errors.
module apb_arbiter
    import apb_pkg::*;
#(
    parameter int APB_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int APB_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLE  = DEF_TIMEOUT_CYCLE
) (
    input  logic                              apb_clk_in,
    input  logic                              apb_rst_in,
    input  logic [NUM_REQ-1:0]                req_valid_in,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr_in,
    input  logic [NUM_REQ-1:0]                req_write_in,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata_in,
    output logic [NUM_REQ-1:0]                req_done_out,
    output logic [APB_DATA_WIDTH-1:0]         req_rdata_out,
    output logic                              req_error_out,
    output logic [APB_ADDR_WIDTH-1:0]         apb_addr_out,
    output logic                              apb_write_out,
    output logic [APB_DATA_WIDTH-1:0]         apb_wdata_out,
    output logic                              apb_psel_out,
    output logic                              apb_penable_out,
`ifdef APB_SLVERR_EN
    input  logic                              apb_slverr_in,
`endif
    input  logic [APB_DATA_WIDTH-1:0]         apb_rdata_in,
    input  logic                              apb_ready_in
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLE + 1);

    apb_state_t          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  rr_grant;
    logic [IW-1:0]       rr_index, rr_next;
    logic [APB_ADDR_WIDTH-1:0] addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_d, rdata_d;
    logic                write_d, psel_d, penable_d, error_d, slverr;
    logic [NUM_REQ-1:0]  done_d;

`ifdef APB_SLVERR_EN
    assign slverr = apb_slverr_in;
`else
    assign slverr = 1'b0;
`endif

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req      (req_valid_in),
        .ptr      (ptr_q),
        .grant    (rr_grant),
        .index    (rr_index),
        .next_ptr (rr_next)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        addr_d    = apb_addr_out;
        write_d   = apb_write_out;
        wdata_d   = apb_wdata_out;
        psel_d    = apb_psel_out;
        penable_d = apb_penable_out;
        done_d    = '0;
        rdata_d   = '0;
        error_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|req_valid_in) begin
                    state_d   = SETUP;
                    ptr_d     = rr_next;
                    grant_d   = rr_grant;
                    addr_d    = req_addr_in[rr_index*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                    wdata_d   = req_wdata_in[rr_index*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                    write_d   = req_write_in[rr_index];
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // Ready wins over a timeout reached in the same cycle.
                if (apb_ready_in) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = grant_q;
                    error_d   = slverr;
                    rdata_d   = (apb_write_out || slverr) ? '0 : apb_rdata_in;
                end else if (cnt_q == TW'(TIMEOUT_CYCLE - 1)) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = grant_q;
                    error_d   = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
        if (apb_rst_in) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            cnt_q           <= '0;
            grant_q         <= '0;
            apb_addr_out    <= '0;
            apb_write_out   <= 1'b0;
            apb_wdata_out   <= '0;
            apb_psel_out    <= 1'b0;
            apb_penable_out <= 1'b0;
            req_done_out    <= '0;
            req_rdata_out   <= '0;
            req_error_out   <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            cnt_q           <= cnt_d;
            grant_q         <= grant_d;
            apb_addr_out    <= addr_d;
            apb_write_out   <= write_d;
            apb_wdata_out   <= wdata_d;
            apb_psel_out    <= psel_d;
            apb_penable_out <= penable_d;
            req_done_out    <= done_d;
            req_rdata_out   <= rdata_d;
            req_error_out   <= error_d;
        end
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter: APB_DATA_WIDTH, 32, data bus width in bits (multiple of 8).
REQ-002 Parameter: APB_ADDR_WIDTH, 32, address bus width in bits.
REQ-003 Parameter: NUM_REQ, 4, number of requesters (2..8).
REQ-004 Parameter: TIMEOUT_CYCLE, 6, ACCESS cycles with pready low before abort (>=1).
REQ-005 Port: apb_clk_in  in  1  single clock; all state changes on its rising edge.
REQ-006 Port: apb_rst_in  in  1  reset, asynchronous, active-high.
REQ-007 Port: req_valid_in  in  NUM_REQ  per-requester transfer request.
REQ-008 Port: req_addr_in  in  NUM_REQ*APB_ADDR_WIDTH  flattened addresses; requester i occupies slice i.
REQ-009 Port: req_write_in  in  NUM_REQ  1 = write, 0 = read.
REQ-010 Port: req_wdata_in  in  NUM_REQ*APB_DATA_WIDTH  flattened write data.
REQ-011 Port: req_done_out  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-012 Port: req_rdata_out  out  APB_DATA_WIDTH  read data, valid with req_done_out.
REQ-013 Port: req_error_out  out  1  transfer error, valid with req_done_out.
REQ-014 Port: apb_addr_out / apb_write_out / apb_wdata_out  out  APB_ADDR_WIDTH / 1 / APB_DATA_WIDTH  APB master address, direction and write data.
REQ-015 Port: apb_psel_out, apb_penable_out  out  1 each  APB select and enable.
REQ-016 Port: apb_rdata_in  in  APB_DATA_WIDTH; apb_ready_in  in  1  APB slave read data and ready.

Function
REQ-017 The FSM SHALL use states IDLE, SETUP and ACCESS, with all outputs registered.
REQ-018 In IDLE, when any req_valid_in bit is set, the arbiter SHALL grant round-robin starting at pointer ptr, latch the winner's addr/write/wdata and enter SETUP.
REQ-019 SETUP SHALL last exactly one cycle with psel=1 and penable=0, then enter ACCESS with psel=1 and penable=1.
REQ-020 apb_addr_out, apb_write_out and apb_wdata_out SHALL remain constant from SETUP through the last ACCESS cycle, whatever the requester inputs do.
REQ-021 In ACCESS with apb_ready_in=1, the block SHALL pulse req_done_out[grant] for one cycle, drive req_rdata_out = read ? apb_rdata_in : 0, drive psel=penable=0 and return to IDLE.
REQ-022 After a grant to i, ptr SHALL become (i+1) mod NUM_REQ, so no requester waits more than NUM_REQ-1 transfers.
REQ-023 The minimum transfer is 3 cycles (IDLE grant, SETUP, ACCESS); back-to-back transfers SHALL pass through IDLE for one cycle.
REQ-024 A timeout counter of width $clog2(TIMEOUT_CYCLE+1) SHALL count ACCESS cycles with ready low and clear in IDLE.
REQ-025 When the counter reaches TIMEOUT_CYCLE, the block SHALL abort: done pulse, req_error_out=1, req_rdata_out=0, psel/penable low, go to IDLE.
REQ-026 Ready arriving in the same cycle the timeout is reached SHALL count as normal completion, not an error.
REQ-027 Deasserting req_valid_in of the granted requester mid-transfer SHALL NOT cancel the transfer.
REQ-028 Each requester SHALL hold valid and payload until its done pulse; the arbiter SHALL sample them only in IDLE.

Reset
REQ-029 On apb_rst_in=1, all outputs, the counter and ptr SHALL go to 0 and the FSM to IDLE immediately, including mid-transfer.
REQ-030 After reset release, no request SHALL be granted before the first rising edge.

Configuration
REQ-031 With APB_SLVERR_EN defined, the block SHALL add input apb_slverr_in (1 bit), and req_error_out SHALL equal apb_slverr_in on completion, with req_rdata_out forced to 0 when it is set.
REQ-032 Without APB_SLVERR_EN, the port SHALL be absent and req_error_out SHALL be set only by timeout.

Structure
REQ-033 State encodings and the default parameter values SHALL reside in the shared package apb_pkg.
REQ-034 Grant selection and ptr update SHALL be a sub-module apb_rr_arbiter (inputs: request vector, ptr; outputs: one-hot grant, index).

Verification
REQ-035 A single read with req_valid_in=0001, addr 0x10, slave ready in the first ACCESS cycle and rdata 0xA5A5A5A5 -> psel high for 2 cycles, done[0] on cycle 3, rdata 0xA5A5A5A5, error 0.
REQ-036 All four requesters held valid from reset -> grants in order 0,1,2,3,0; each done pulse is single-cycle.
REQ-037 A write of 0xDEADBEEF with ready delayed 3 cycles -> addr/wdata stable for 5 cycles, req_rdata_out=0, error 0.
REQ-038 TIMEOUT_CYCLE=6 with ready never asserted -> abort after 6 ACCESS cycles, error=1, rdata=0; the next requester is granted afterwards.
REQ-039 Reset asserted in ACCESS -> psel/penable/done drop asynchronously; the first grant after reset goes to requester 0.
REQ-040 With APB_SLVERR_EN, a read with slverr=1 and ready=1 -> error=1, rdata=0.
